// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-issue RV32I core.
// Performance counters are built only when PERF_CNT_EN is defined; otherwise the ports read 0.
//
// state  | meaning
// IDLE   | waiting for i_start (i_halt blocks the start)
// FETCH  | imem request pending; IR captured on ready
// DECODE | latch decoded strobes; trap on illegal
// EXEC   | resolve branch, route to MEM or WB
// MEM    | dmem request pending; store retires on ready
// WB     | register write and PC update
// TRAP   | terminal until reset; cause held
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_halt,
  input  logic             i_reg_write,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic             i_branch,
  input  logic             i_jump,
  input  logic             i_illegal,
  input  logic             i_alu_zero,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  output logic             o_imem_req,
  output logic             o_ir_load,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic             o_rf_we,
  output logic             o_pc_we,
  output logic             o_pc_sel,
  output logic [2:0]       o_state,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret
);

  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  state_t           next_fetch;
  logic [1:0]       cause_q, cause_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  logic             rw_q, mr_q, mw_q, br_q, jp_q;

  // An instruction boundary is the only place a halt takes effect.
  assign next_fetch = i_halt ? S_IDLE : S_FETCH;
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cause_q <= 2'b00;
      tmo_q   <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      jp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tmo_q   <= tmo_d;
      if (state_q == S_DECODE) begin
        rw_q <= i_reg_write;
        mr_q <= i_mem_read;
        mw_q <= i_mem_write;
        br_q <= i_branch;
        jp_q <= i_jump;
      end
    end
  end

  // Counter only advances while a request waits; any other cycle clears it.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_FETCH && !i_imem_ready) || (state_q == S_MEM && !i_dmem_ready))
      tmo_d = tmo_q + TMO_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    o_imem_req = 1'b0;
    o_ir_load  = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_halt) state_d = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          o_ir_load = 1'b1;
          state_d   = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (i_illegal) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (br_q) begin
          o_pc_we  = 1'b1;
          o_pc_sel = i_alu_zero;
          state_d  = next_fetch;
        end else if (mr_q || mw_q) begin
          state_d = S_MEM;
        end else if (jp_q || rw_q) begin
          state_d = S_WB;
        end else begin
          o_pc_we = 1'b1;
          state_d = next_fetch;
        end
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = mw_q;
        if (i_dmem_ready) begin
          if (mr_q) begin
            state_d = S_WB;
          end else begin
            o_pc_we = 1'b1;
            state_d = next_fetch;
          end
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_WB: begin
        o_rf_we  = 1'b1;
        o_pc_we  = 1'b1;
        o_pc_sel = jp_q;
        state_d  = next_fetch;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_state      = state_q;
  assign o_trap       = (state_q == S_TRAP);
  assign o_trap_cause = cause_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
      if (o_pc_we) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign o_cycle_cnt = cycle_q;
  assign o_instret   = instret_q;
`else
  assign o_cycle_cnt = '0;
  assign o_instret   = '0;
`endif

endmodule
